// File: rtl/mux_scan_sequencer_if.sv
// Bus between the mux scan sequencer, its requester and the downstream N:1 mux.
// The sequencer sits on the slave modport. The requester/mux side sits on the master modport.
interface mux_scan_sequencer_if #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
);
    logic             start;
    logic             Y_in;
    logic [SEL_W-1:0] Sel;
    logic [N_CH-1:0]  data;
    logic             valid;
    logic             busy;

    // Sequencer view: takes scan requests and mux output, drives select and results
    modport slave (
        input  start,
        input  Y_in,
        output Sel,
        output data,
        output valid,
        output busy
    );

    // Requester / mux view: issues scan requests and returns the muxed bit
    modport master (
        output start,
        output Y_in,
        input  Sel,
        input  data,
        input  valid,
        input  busy
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scans an N_CH:1 bit mux one channel at a time. Sel is held for SETTLE cycles,
// then Y_in is sampled into a shadow register. Once the last channel has been
// sampled, the whole word is published on data together with a one-cycle valid pulse.
// Optional build macro CONTINUOUS_SCAN_EN adds a 'cont' input. When cont is high,
// scans restart without passing through IDLE.
module mux_scan_sequencer #(
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef CONTINUOUS_SCAN_EN
    input  logic                 cont,
`endif
    mux_scan_sequencer_if.slave  bus
);

    localparam int               CNT_W    = $clog2(SETTLE) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE_ST = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0]    shadow_q, shadow_d;
    logic [N_CH-1:0]    data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               restart;

    // Decide whether a finished scan rolls straight into the next one
`ifdef CONTINUOUS_SCAN_EN
    assign restart = cont;
`else
    assign restart = 1'b0;
`endif

    // Next-state logic for the scan FSM, select, settle counter and result registers
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETTLE_ST;
                    sel_d   = '0;
                    cnt_d   = CNT_LOAD;
                end
            end

            SETTLE_ST: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            SAMPLE: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (sel_q == SEL_W'(k)) begin
                        shadow_d[k] = bus.Y_in;
                    end
                end
                if (sel_q == LAST_SEL) begin
                    data_d  = shadow_d;
                    valid_d = 1'b1;
                    sel_d   = '0;
                    if (restart) begin
                        state_d = SETTLE_ST;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    sel_d   = sel_q + 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE_ST;
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // All state and registered outputs. Reset returns to IDLE and discards any partial scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.Sel   = sel_q;
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule
